// File: rtl/shift_issue_unit.sv
// Two-stage shift issue stage: S1 forms shifter operands (A = rt, amount in the B[10:6] slot), S2 registers the result.
// Optional build macro SHIFT_CNT_EN adds the op_count completed-operation counter.
module shift_issue_unit #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_inst,
    input  logic [W-1:0]     in_rs,
    input  logic [W-1:0]     in_rt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_res,
    output logic             out_err
`ifdef SHIFT_CNT_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; a stage
    // advances when it is empty or the stage after it is advancing.

    if (W != 32 || CNT_W < 1) begin : g_bad_cfg
        $error("shift_issue_unit supports W == 32 and CNT_W >= 1 only");
    end

    typedef enum logic [1:0] {
        OP_SLL = 2'd0,
        OP_SRL = 2'd1,
        OP_SRA = 2'd2
    } shift_op_e;

    logic            s1_valid_q, s1_valid_d;
    logic [W-1:0]    s1_a_q, s1_a_d;
    logic [4:0]      s1_amt_q, s1_amt_d;   // the B[10:6] field of the srl32 operand convention
    shift_op_e       s1_op_q, s1_op_d;
    logic            s1_err_q, s1_err_d;

    logic            s2_valid_q, s2_valid_d;
    logic [W-1:0]    s2_res_q, s2_res_d;
    logic            s2_err_q, s2_err_d;

    logic            s1_adv, s2_adv;
    shift_op_e       dec_op;
    logic            dec_var, dec_err;
    logic [W-1:0]    shift_res;

    always_comb begin
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        dec_op  = OP_SLL;
        dec_var = 1'b0;
        dec_err = 1'b0;
        case (in_inst[5:0])
            6'b000000: dec_op = OP_SLL;
            6'b000010: dec_op = OP_SRL;
            6'b000011: dec_op = OP_SRA;
            6'b000100: begin dec_op = OP_SLL; dec_var = 1'b1; end
            6'b000110: begin dec_op = OP_SRL; dec_var = 1'b1; end
            6'b000111: begin dec_op = OP_SRA; dec_var = 1'b1; end
            default:   dec_err = 1'b1;
        endcase

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_amt_d   = s1_amt_q;
        s1_op_d    = s1_op_q;
        s1_err_d   = s1_err_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d   = in_rt;
                s1_amt_d = dec_var ? in_rs[4:0] : in_inst[10:6];
                s1_op_d  = dec_op;
                s1_err_d = dec_err;
            end
        end

        case (s1_op_q)
            OP_SRL:  shift_res = s1_a_q >> s1_amt_q;
            OP_SRA:  shift_res = W'($signed(s1_a_q) >>> s1_amt_q);
            default: shift_res = s1_a_q << s1_amt_q;
        endcase

        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_err_d   = s2_err_q;
        // An empty S1 leaves S2 data untouched; only the valid bit drops.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = s1_err_q ? '0 : shift_res;
                s2_err_d = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_amt_q   <= '0;
            s1_op_q    <= OP_SLL;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_amt_q   <= s1_amt_d;
            s1_op_q    <= s1_op_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_err   = s2_err_q;

`ifdef SHIFT_CNT_EN
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    // Counts every delivered result, error results included; wraps naturally.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (s2_valid_q && out_ready) begin
            op_cnt_d = op_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign op_count = op_cnt_q;
`endif

endmodule
